tbl_lookup_rd: RTL
==================

TBL_LOOKUP_RD -- requirements
Module: tbl_lookup_rd

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 5, table address width.
REQ-002 SHALL have parameter DATA_BITS, default 32, table entry width.
REQ-003 SHALL have parameter TAG_BITS, default 8, request metadata width carried alongside each lookup.
REQ-004 SHALL have port clk  input  1  single clock for all logic; one clock only.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports req_valid input 1, req_ready output 1, req_addr input ADDR_BITS, req_tag input TAG_BITS: lookup request channel.
REQ-007 SHALL have ports ram_enb output 1, ram_addrb output ADDR_BITS, ram_doutb input DATA_BITS: connection to the table memory read port.
REQ-008 SHALL have ports rsp_valid output 1, rsp_ready input 1, rsp_data output DATA_BITS, rsp_tag output TAG_BITS: lookup response channel.
REQ-009 SHALL have port lookup_cnt  output 32  count of completed responses.

Function
REQ-010 SHALL treat the memory read port as fixed 1-cycle latency: ram_doutb is valid in the cycle after ram_enb=1 and is not relied on afterwards.
REQ-011 SHALL accept a request in any cycle with req_valid=1 and req_ready=1 ("issue").
REQ-012 SHALL drive ram_enb = req_valid & req_ready and ram_addrb = req_addr combinationally; no memory read otherwise.
REQ-013 SHALL register one in-flight flag and the tag of the issued request; the flag is set on issue and cleared the following cycle unless a new issue occurs.
REQ-014 SHALL, in the cycle after an issue, push {ram_doutb, in-flight tag} into a 4-entry response FIFO.
REQ-015 SHALL compute req_ready from registers only: req_ready = (occupancy + in-flight) < 4, and 0 while rst=1; it SHALL never depend on rsp_ready or req_valid.
REQ-016 SHALL guarantee by REQ-015 that the FIFO never overflows and no memory result is dropped.
REQ-017 SHALL drive rsp_valid = (occupancy != 0) and present rsp_data/rsp_tag from the FIFO head register storage.
REQ-018 SHALL pop the head on rsp_valid & rsp_ready; push and pop in the same cycle leave occupancy unchanged.
REQ-019 SHALL hold rsp_data/rsp_tag stable while rsp_valid=1 and rsp_ready=0.
REQ-020 SHALL preserve request order: responses emerge in issue order.
REQ-021 SHALL give latency of 2 cycles: issue in cycle N -> rsp_valid=1 earliest in cycle N+2.
REQ-022 SHALL sustain one issue and one response per cycle when rsp_ready is held 1.
REQ-023 SHALL use 2-bit wrapping read/write pointers and a 3-bit occupancy (0..4).
REQ-024 SHALL increment lookup_cnt by 1 on each response handshake, wrapping 0xFFFFFFFF -> 0.

Reset
REQ-025 SHALL, on a clock edge with rst=1, clear occupancy, pointers, in-flight flag and lookup_cnt to 0.
REQ-026 SHALL hold rsp_valid=0, req_ready=0, ram_enb=0 while rst=1; rsp_data/rsp_tag are don't-care when rsp_valid=0.
REQ-027 SHALL discard any in-flight read and buffered responses when rst asserts mid-operation; the first cycle after rst deasserts has req_ready=1.

Verification
REQ-028 Single lookup: memory[3]=0xDEADBEEF, issue addr=3 tag=0x11 in cycle N, rsp_ready=1 -> ram_enb=1 ram_addrb=3 in N; rsp_valid=1 data=0xDEADBEEF tag=0x11 in N+2; lookup_cnt=1.
REQ-029 Streaming: 16 back-to-back requests addr 0..15, rsp_ready=1 -> req_ready never drops, 16 responses in order on consecutive cycles, lookup_cnt=16.
REQ-030 Backpressure: rsp_ready=0, req_valid=1 continuously -> exactly 4 issues, then req_ready=0; rsp_data of head stable; release rsp_ready -> 4 ordered responses, issuing resumes.
REQ-031 Simultaneous push/pop: occupancy 2, issue and pop every cycle for 10 cycles -> occupancy stays 2, no loss, tags match issue order.
REQ-032 Reset mid-operation: 3 responses buffered plus one in-flight, assert rst 1 cycle -> next cycle rsp_valid=0, lookup_cnt=0, req_ready=1; no stale response ever appears.
REQ-033 Counter wrap: force lookup_cnt to 0xFFFFFFFF via 2^32-1 handshakes or a backdoor deposit, complete one response -> lookup_cnt=0.

Source files
------------

// File: rtl/tbl_lookup_rd.sv
// tbl_lookup_rd: table lookup with 1-cycle memory read and 4-entry ordered response FIFO
module tbl_lookup_rd #(
  parameter int ADDR_BITS = 5,
  parameter int DATA_BITS = 32,
  parameter int TAG_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [TAG_BITS-1:0]  req_tag,
  output logic                 ram_enb,
  output logic [ADDR_BITS-1:0] ram_addrb,
  input  logic [DATA_BITS-1:0] ram_doutb,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_BITS-1:0] rsp_data,
  output logic [TAG_BITS-1:0]  rsp_tag,
  output logic [31:0]          lookup_cnt
);
  logic [DATA_BITS-1:0] dmem [4];
  logic [TAG_BITS-1:0]  tmem [4];
  logic [TAG_BITS-1:0]  tag_q;
  logic [1:0]           wptr, rptr;
  logic [2:0]           occ;
  logic                 inflight, issue, pop;
  // the in-flight read reserves a slot, so the FIFO can never overflow
  assign req_ready = ~rst & ((occ + {2'b0, inflight}) < 3'd4);
  assign issue     = req_valid & req_ready;
  assign ram_enb   = issue;
  assign ram_addrb = req_addr;
  assign rsp_valid = ~rst & (occ != 3'd0);
  assign pop       = rsp_valid & rsp_ready;
  assign rsp_data  = dmem[rptr];
  assign rsp_tag   = tmem[rptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      occ        <= '0;
      wptr       <= '0;
      rptr       <= '0;
      inflight   <= 1'b0;
      lookup_cnt <= '0;
    end else begin
      inflight <= issue;
      occ      <= occ + {2'b0, inflight} - {2'b0, pop};
      if (inflight) wptr <= wptr + 2'd1;
      if (pop) rptr <= rptr + 2'd1;
      if (pop) lookup_cnt <= lookup_cnt + 32'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (issue) tag_q <= req_tag;
    if (inflight) begin
      dmem[wptr] <= ram_doutb;
      tmem[wptr] <= tag_q;
    end
  end
endmodule
